// File: rtl/fifo_rd_stream.sv
// Read-domain adapter for the async FIFO. It pops words into a 2-entry buffer and drives a valid/ready stream with m_last packet tags.
// A word popped at edge N is on m_data from edge N. A stall absorbs at most 2 words, and rinc never depends on m_ready.
module fifo_rd_stream #(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNTW    = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  input  logic             flush,
  output logic [CNTW-1:0]  rd_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int            PW       = 8;
  localparam logic [PW-1:0] POS_LAST = PW'(PKT_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [DSIZE-1:0] head_dat;
  logic [DSIZE-1:0] tail_dat;
  logic             head_last;
  logic             tail_last;
  logic [PW-1:0]    pkt_pos;
  logic             push;
  logic             pop;
  logic             push_last;
  logic             load_head_new;
  logic             load_head_tail;
  logic             load_tail;

  // Gating rinc with rrst_n keeps the FIFO from being popped while reset is held.
  assign rinc      = rrst_n && !rempty && (state != TWO) && !flush;
  assign push      = rinc;
  assign m_valid   = (state != EMPTY);
  assign pop       = m_valid && m_ready;
  assign m_data    = head_dat;
  assign m_last    = head_last;
  assign push_last = (pkt_pos == POS_LAST);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_head_new  = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt     = ONE;
          load_head_new = 1'b1;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_nxt = TWO;
          load_tail = 1'b1;
        end else if (!push && pop) begin
          state_nxt = EMPTY;
        end else if (push && pop) begin
          load_head_new = 1'b1;
        end
      end
      TWO: begin
        if (pop) begin
          state_nxt      = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over everything; rinc is already low, so no word can be lost.
    if (flush) begin
      state_nxt      = EMPTY;
      load_head_new  = 1'b0;
      load_head_tail = 1'b0;
      load_tail      = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_dat  <= '0;
      head_last <= 1'b0;
      tail_dat  <= '0;
      tail_last <= 1'b0;
    end else begin
      if (load_head_new) begin
        head_dat  <= rdata;
        head_last <= push_last;
      end else if (load_head_tail) begin
        head_dat  <= tail_dat;
        head_last <= tail_last;
      end
      if (load_tail) begin
        tail_dat  <= rdata;
        tail_last <= push_last;
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pkt_pos <= '0;
    end else if (flush) begin
      pkt_pos <= '0;
    end else if (push) begin
      pkt_pos <= push_last ? '0 : pkt_pos + PW'(1);
    end
  end

  // A handshake in a flush cycle is still a delivered word.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, and a scoreboard holds the expected {last,data} stream.
module tb_fifo_rd_stream;
  localparam int DSIZE   = 8;
  localparam int PKT_LEN = 4;
  localparam int CNTW    = 4;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  logic             flush;
  logic [CNTW-1:0]  rd_count;

  int checks = 0;
  int errors = 0;

  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE:0]   sb_q[$];
  int               pkt_pos     = 0;
  int               exp_count   = 0;
  int               rinc_pulses = 0;
  int               delivered   = 0;
  logic [31:0]      last_mask   = '0;
  logic             prev_stall  = 1'b0;
  logic [DSIZE:0]   prev_word   = '0;
  int               saved_count = 0;

  fifo_rd_stream #(.DSIZE(DSIZE), .PKT_LEN(PKT_LEN), .CNTW(CNTW)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .flush    (flush),
    .rd_count (rd_count)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one cycle from a negedge: present FIFO head, sample before the edge, update the models, check rd_count after.
  task automatic step();
    logic           r;
    logic           hs;
    logic [DSIZE:0] got;
    logic [DSIZE:0] e;
    logic [DSIZE-1:0] w;
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 'x : fifo_q[0];
    #1;
    r   = rinc;
    hs  = m_valid && m_ready;
    got = {m_last, m_data};
    if (prev_stall) check("hold_stable", got, prev_word);
    if (flush) check("rinc_in_flush", r, 1'b0);
    if (hs) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("word", got, e);
      end
      if (m_last) last_mask[delivered] = 1'b1;
      delivered++;
      exp_count++;
    end
    if (r) begin
      w = fifo_q.pop_front();
      sb_q.push_back({(pkt_pos == PKT_LEN - 1), w});
      pkt_pos = (pkt_pos + 1) % PKT_LEN;
      rinc_pulses++;
    end
    if (flush) begin
      sb_q.delete();
      pkt_pos = 0;
    end
    prev_stall = m_valid && !m_ready && !flush;
    prev_word  = got;
    @(posedge rclk);
    #1;
    check("rd_count", rd_count, exp_count % (1 << CNTW));
    @(negedge rclk);
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || sb_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", fifo_q.size() + sb_q.size(), 0);
    check("idle_after_drain", m_valid, 1'b0);
  endtask

  task automatic model_reset();
    fifo_q.delete();
    sb_q.delete();
    pkt_pos    = 0;
    exp_count  = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    rrst_n  = 1'b0;
    rempty  = 1'b0;
    rdata   = 8'h99;
    m_ready = 1'b0;
    flush   = 1'b0;
    #3;
    check("rst_valid", m_valid, 1'b0);
    check("rst_data", m_data, 8'h00);
    check("rst_last", m_last, 1'b0);
    check("rst_count", rd_count, 0);
    check("rst_rinc", rinc, 1'b0);
    model_reset();
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;

    // Basic drain
    delivered = 0;
    last_mask = '0;
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    m_ready = 1'b1;
    step();
    check("first_valid", m_valid, 1'b1);
    check("first_data", m_data, 8'h11);
    run_drain(20);
    check("basic_count", rd_count, 4);
    check("basic_last_mask", last_mask, 32'h8);
    rempty = 1'b1;
    #1;
    check("rinc_when_empty", rinc, 1'b0);
    @(negedge rclk);

    // Backpressure
    rinc_pulses = 0;
    delivered   = 0;
    m_ready     = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'hA0 + 8'(i));
    repeat (6) step();
    check("bp_rinc_pulses", rinc_pulses, 2);
    check("bp_valid", m_valid, 1'b1);
    check("bp_head", m_data, 8'hA0);
    m_ready = 1'b1;
    run_drain(30);
    check("bp_delivered", delivered, 6);

    // Packet wrap: an empty-buffer flush realigns the packet position first
    flush = 1'b1;
    step();
    flush     = 1'b0;
    delivered = 0;
    last_mask = '0;
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'h30 + 8'(i));
    run_drain(40);
    check("wrap_last_mask", last_mask, 32'h088);

    // Flush with two words buffered
    fifo_q.push_back(8'h4F);
    run_drain(10);
    m_ready = 1'b0;
    fifo_q  = '{8'h50, 8'h51, 8'h52};
    repeat (3) step();
    check("pre_flush_valid", m_valid, 1'b1);
    saved_count = exp_count;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", m_valid, 1'b0);
    check("flush_count", rd_count, saved_count % (1 << CNTW));
    fifo_q.push_back(8'h53);
    fifo_q.push_back(8'h54);
    fifo_q.push_back(8'h55);
    m_ready   = 1'b1;
    delivered = 0;
    last_mask = '0;
    run_drain(20);
    check("flush_pkt_mask", last_mask, 32'h8);

    // Simultaneous flush and handshake
    m_ready = 1'b0;
    fifo_q.push_back(8'h60);
    step();
    saved_count = exp_count;
    m_ready = 1'b1;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    check("fh_valid", m_valid, 1'b0);
    check("fh_count", rd_count, (saved_count + 1) % (1 << CNTW));

    // Counter wrap, then asynchronous reset mid-stream
    rrst_n = 1'b0;
    model_reset();
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'h70 + 8'(i));
    run_drain(60);
    check("cnt_wrap", rd_count, 1);
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'hC0 + 8'(i));
    repeat (2) step();
    check("mid_valid", m_valid, 1'b1);
    #2;
    rrst_n = 1'b0;
    #1;
    check("arst_valid", m_valid, 1'b0);
    check("arst_count", rd_count, 0);
    check("arst_rinc", rinc, 1'b0);
    model_reset();
    @(negedge rclk);
    rrst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the async FIFO, in the read clock domain.
- Pops words from the FIFO read port (rempty/rinc/rdata) and presents them downstream as a valid/ready stream.
- Holds words in a 2-entry output buffer, so there is no combinational path from m_ready to rinc.
- Tags every PKT_LEN-th word with m_last for packet framing, and counts delivered words.

Parameters:
- DSIZE, 8, data word width; must match the FIFO DSIZE.
- PKT_LEN, 4, words per packet; m_last is set on word PKT_LEN-1 of each packet; legal range 1..256.
- CNTW, 16, width of the delivered-word counter rd_count.

Ports:
- rclk  in  1  read-domain clock; all logic is on its posedge.
- rrst_n  in  1  asynchronous active-low reset.
- rempty  in  1  FIFO empty flag; when 0, rdata holds the head word.
- rdata  in  DSIZE  FIFO head word; combinational from the FIFO memory.
- rinc  out  1  FIFO pop strobe; pops the head word at the rclk edge when rempty=0.
- m_data  out  DSIZE  downstream data, from buffer head.
- m_valid  out  1  downstream valid.
- m_last  out  1  last word of packet, qualified by m_valid.
- m_ready  in  1  downstream ready.
- flush  in  1  synchronous discard of buffered words and packet position.
- rd_count  out  CNTW  words delivered downstream (m_valid && m_ready), wraps modulo 2^CNTW.

Behaviour:
- Reset (rrst_n=0, asynchronous):
  - state=EMPTY; m_valid=0, m_data=0, m_last=0, rd_count=0; pkt position=0.
  - rinc=0 while reset is asserted.
- Buffer state machine, occupancy-encoded: EMPTY (0 entries), ONE (1), TWO (2). Head entry = {data, last flag}.
- rinc = !rempty && (state != TWO) && !flush.
  - Combinational from rempty, state and flush only; never from m_ready.
- push = rinc (the word from rdata is captured at the same edge it is popped).
- pop = m_valid && m_ready.
- m_valid = (state != EMPTY). m_data and m_last always come from the head entry.
- Transitions:
  - EMPTY, push -> ONE.
  - ONE, push & !pop -> TWO.
  - ONE, !push & pop -> EMPTY.
  - ONE, push & pop -> ONE, new word becomes head.
  - TWO, pop -> ONE, second entry becomes head. No push is possible in TWO.
  - Otherwise hold.
- Latency: word popped at edge N appears on m_data with m_valid=1 from edge N onward. That is one cycle after rinc is sampled high, and zero cycles from the m_valid register.
- Throughput: one word per cycle sustained while !rempty and m_ready=1; state stays ONE.
- Stall behaviour: if m_ready=0, at most 2 words are absorbed, then rinc=0 until a pop.
  - m_data and m_last must be stable while m_valid && !m_ready.
- Packet tagging:
  - pkt_pos counter, 0..PKT_LEN-1, advances on each push and wraps to 0.
  - The pushed word's last flag = (pkt_pos == PKT_LEN-1).
  - PKT_LEN=1 means every word has last=1.
- rd_count increments by 1 on each pop and wraps from 2^CNTW-1 to 0.
- Flush (synchronous, highest priority):
  - Next state=EMPTY, pkt_pos=0, rinc=0 in the flush cycle, so no FIFO word is lost to a discarded push.
  - A handshake (pop) in the flush cycle still counts in rd_count.
  - Buffered words not yet accepted are dropped.
- Reset mid-stream: buffer contents are discarded immediately and m_valid drops asynchronously. The FIFO's own rrst_n handling is not this block's concern.
- rdata is sampled only when rinc=1; X on rdata while rempty=1 must not propagate.

Test Plan:
- Basic drain: after reset, FIFO holds 0x11,0x22,0x33,0x44 with m_ready=1 -> m_data 0x11..0x44 on consecutive cycles; m_last=1 only with 0x44; rd_count=4; rinc=0 once rempty=1.
- Backpressure: FIFO holds 6 words, m_ready=0 -> rinc pulses exactly twice, m_valid=1 with m_data=first word held stable. Release m_ready -> all 6 words delivered in order, no duplicates or gaps.
- Packet wrap: PKT_LEN=4, stream 10 words -> m_last=1 on words 4 and 8 only; word 9 starts a new packet at pkt_pos=0.
- Flush: 2 words buffered, m_ready=0, assert flush 1 cycle -> m_valid=0 next cycle and rinc=0 during flush. The next FIFO word arrives with pkt_pos=0; rd_count is unchanged.
- Simultaneous flush+handshake: state ONE, m_ready=1, flush=1 -> rd_count increments by 1; state=EMPTY.
- Counter wrap and async reset: CNTW=4, deliver 17 words -> rd_count=1. Then assert rrst_n=0 mid-stream -> m_valid=0, rd_count=0, rinc=0 immediately, without waiting for an rclk edge.
